// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and mode constants.
// Imported by the top and by the testbench.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_slice.sv
// One-bit add/subtract cell: inverts b when m is set, then performs a full add.
// Subtraction becomes A + ~B + 1 when the caller seeds cin with m.
module addsub_slice (
    input  logic a,
    input  logic b,
    input  logic m,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_bx;
    logic w_p;

    assign w_bx = b ^ m;
    assign w_p  = a ^ w_bx;
    assign s    = w_p ^ cin;
    assign cout = (a & w_bx) | (cin & w_p);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are consumed LSB-first, one bit per clock,
// through a single addsub_slice and a carry flip-flop, under a start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output state_t           dbg_state
);

    // Handshake: start is accepted on a rising edge only while the FSM is in IDLE
    // or DONE; busy is high for the WIDTH cycles of RUN; done is a one-cycle pulse
    // marking result/cout/overflow valid, and those hold until the next accepted start.

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_sum;
    logic             w_slice_cout;
    logic             w_accept;
    logic             w_last;

    addsub_slice u_slice (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .m    (r_mode),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_slice_cout)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_state == RUN) begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_carry  <= w_slice_cout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // r_carry here is the carry into the MSB, so overflow is formed directly.
                r_cout  <= w_slice_cout;
                r_ovf   <= r_carry ^ w_slice_cout;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
            end
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_mode  <= mode;
                r_carry <= (mode == MODE_SUB);
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= RUN;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub (WIDTH = 8) with a queue-based scoreboard
// that checks every done pulse against the expected value and expected cycle.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  state_t       dbg_state;

  int checks;
  int failures;
  int cyc;

  // Expected entry: {overflow, cout, result}; exp_cyc_q holds the cycle count at which done is due.
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_done;
  initial prev_done = 1'b0;

  always @(negedge clk) begin
    logic [W+1:0] e;
    int           ec;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=0x%0h expected=no_done (t=%0t)", result, $time);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("sb_result",   32'(result),   32'(e[W-1:0]));
        chk("sb_cout",     32'(cout),     32'(e[W]));
        chk("sb_overflow", 32'(overflow), 32'(e[W+1]));
        chk("sb_done_cycle", 32'(cyc), 32'(ec));
        chk("sb_busy_low_at_done", 32'(busy), 32'(0));
      end
      if (prev_done) chk("done_single_cycle", 32'(prev_done & done), 32'(0));
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is seen at the next posedge (E0), done due WIDTH cycles later.
  task automatic issue(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] er, input logic ecout, input logic eovf,
                       input bit push);
    start = 1'b1;
    mode  = m;
    a     = va;
    b     = vb;
    if (push) begin
      exp_q.push_back({eovf, ecout, er});
      exp_cyc_q.push_back(cyc + 1 + W);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom_range(255, 0);
    b     = $urandom_range(255, 0);
    mode  = $urandom_range(1, 0);
  endtask

  // Waits (bounded) at negedges until done, counting busy cycles; pre = busy cycles already seen.
  task automatic wait_done(input int pre);
    int  n;
    bit  seen;
    n    = pre;
    seen = 0;
    for (int k = 0; k < 4 * W; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("busy_cycles", 32'(n), 32'(W));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = MODE_ADD;
    a        = '0;
    b        = '0;

    @(negedge clk);
    chk("rst_busy",     32'(busy),      32'(0));
    chk("rst_done",     32'(done),      32'(0));
    chk("rst_result",   32'(result),    32'(0));
    chk("rst_cout",     32'(cout),      32'(0));
    chk("rst_overflow", 32'(overflow),  32'(0));
    chk("rst_state",    32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Plain add, then confirm outputs hold across IDLE.
    issue(MODE_ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("hold_result",   32'(result),    32'(8'h08));
    chk("hold_state",    32'(dbg_state), 32'(IDLE));
    chk("hold_busy",     32'(busy),      32'(0));

    issue(MODE_ADD, 8'h64, 8'h32, 8'h96, 1'b0, 1'b1, 1);
    wait_done(0);
    @(negedge clk);
    issue(MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1);
    wait_done(0);
    @(negedge clk);
    issue(MODE_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1);
    wait_done(0);
    @(negedge clk);
    issue(MODE_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1);
    wait_done(0);
    @(negedge clk);

    // start re-pulsed in RUN cycle 3 with different operands: must be ignored.
    issue(MODE_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    mode  = MODE_SUB;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    repeat (3) @(negedge clk);

    // Back-to-back: new start presented in the DONE cycle, no IDLE gap.
    issue(MODE_ADD, 8'h21, 8'h11, 8'h32, 1'b0, 1'b0, 1);
    wait_done(0);
    issue(MODE_SUB, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1);
    wait_done(0);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 4, away from any clock edge.
    issue(MODE_ADD, 8'h0F, 8'h0F, 8'h1E, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",     32'(busy),      32'(0));
    chk("arst_result",   32'(result),    32'(0));
    chk("arst_cout",     32'(cout),      32'(0));
    chk("arst_overflow", 32'(overflow),  32'(0));
    chk("arst_state",    32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(MODE_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1);
    wait_done(0);

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
